// File: rtl/dmem_mmio_unit.sv
// dmem_mmio_unit: MEM-stage data memory with registered loads, fault reporting and a buffered UART TX queue.
module dmem_mmio_unit #(
    parameter logic [31:0] DMEM_BASE      = 32'h1000_0000,
    parameter int unsigned DMEM_BYTES     = 131072,
    parameter logic [31:0] UART_TX_ADDR   = 32'h2000_0000,
    parameter logic [31:0] UART_STAT_ADDR = 32'h2000_0004,
    parameter int unsigned TXQ_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        load_signed,
    input  logic [1:0]  load_size,
    input  logic [1:0]  store_size,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        stall,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int AW = $clog2(DMEM_BYTES);
    localparam int PW = $clog2(TXQ_DEPTH);

    logic [7:0]    mem_q [DMEM_BYTES];
    logic [7:0]    txq_q [TXQ_DEPTH];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [PW:0]   cnt_q;
    logic [31:0]   rdata_q, rdata_d, off, word, sh, ld_val, wd;
    logic          rvalid_q, fault_q;
    logic [1:0]    cause_q, cause_d;
    logic [AW-1:0] idx, wb;
    logic [3:0]    be;
    logic          in_dmem, is_tx, is_stat, ld_mis, st_mis, full, empty;
    logic          ld_ok, st_ok, push, pop, dmem_we;

    assign off     = addr - DMEM_BASE;
    assign in_dmem = (addr >= DMEM_BASE) && (off < DMEM_BYTES);
    assign is_tx   = addr == UART_TX_ADDR;
    assign is_stat = addr == UART_STAT_ADDR;
    assign idx     = off[AW-1:0];
    assign wb      = {idx[AW-1:2], 2'b00};
    assign ld_mis  = (load_size == 2'b01 && addr[0]) || (load_size[1] && addr[1:0] != 2'b00);
    assign st_mis  = (store_size == 2'b01 && addr[0]) || (store_size[1] && addr[1:0] != 2'b00);

    // First matching rule wins; a nonzero cause suppresses every side effect.
    assign cause_d = (mem_read && mem_write)               ? 2'b11 :
                     (mem_read && !in_dmem && !is_stat)    ? 2'b11 :
                     (mem_write && !in_dmem && !is_tx)     ? 2'b11 :
                     (mem_read && in_dmem && ld_mis)       ? 2'b01 :
                     (mem_write && in_dmem && st_mis)      ? 2'b10 : 2'b00;

    assign full    = cnt_q == (PW+1)'(TXQ_DEPTH);
    assign empty   = cnt_q == '0;
    assign ld_ok   = mem_read && cause_d == 2'b00;
    assign st_ok   = mem_write && cause_d == 2'b00;
    assign stall   = st_ok && is_tx && full;
    assign push    = st_ok && is_tx && !full;
    assign pop     = !empty && uart_tx_ready;
    assign dmem_we = st_ok && in_dmem;

    // Read the containing word once, then shift the addressed lanes down.
    assign word    = {mem_q[wb + AW'(3)], mem_q[wb + AW'(2)], mem_q[wb + AW'(1)], mem_q[wb]};
    assign sh      = word >> {idx[1:0], 3'b000};
    assign ld_val  = load_size[1] ? sh :
                     load_size[0] ? {{16{load_signed & sh[15]}}, sh[15:0]} :
                                    {{24{load_signed & sh[7]}}, sh[7:0]};
    assign rdata_d = !ld_ok ? rdata_q : is_stat ? {30'b0, empty, full} : ld_val;

    assign be = (store_size[1] ? 4'b1111 : store_size[0] ? 4'b0011 : 4'b0001) << idx[1:0];
    assign wd = wdata << {idx[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (dmem_we)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem_q[wb + AW'(k)] <= wd[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < TXQ_DEPTH; i++) txq_q[i] <= 8'h00;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= ld_ok;
            fault_q  <= cause_d != 2'b00;
            cause_q  <= cause_d;
            rptr_q   <= rptr_q + PW'(pop);
            wptr_q   <= wptr_q + PW'(push);
            cnt_q    <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            if (push) txq_q[wptr_q] <= wdata[7:0];
        end
    end

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;
    assign uart_tx_data  = txq_q[rptr_q];
    assign uart_tx_valid = !empty;
endmodule

// File: tb/tb_dmem_mmio_unit.sv
// tb_dmem_mmio_unit: directed table, hand sequences and random traffic checked against a queue/array model.
module tb_dmem_mmio_unit;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned BYTES = 131072;
    localparam logic [31:0] TXA   = 32'h2000_0000;
    localparam logic [31:0] STA   = 32'h2000_0004;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_read = 0, mem_write = 0, load_signed = 0, uart_tx_ready = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [1:0]  load_size = 0, store_size = 0;
    logic [31:0] rdata;
    logic        rvalid, fault, stall, uart_tx_valid;
    logic [1:0]  fault_cause;
    logic [7:0]  uart_tx_data;

    dmem_mmio_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .wdata(wdata), .load_signed(load_signed), .load_size(load_size), .store_size(store_size),
        .rdata(rdata), .rvalid(rvalid), .fault(fault), .fault_cause(fault_cause), .stall(stall),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0]  mdl [logic [31:0]];
    logic [7:0]  q [$];
    logic [31:0] m_rdata = 0;
    logic        m_rvalid = 0, m_fault = 0, last_stall = 0;
    logic [1:0]  m_cause = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return s[1] ? 4 : s[0] ? 2 : 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rdata = 0; m_rvalid = 0; m_fault = 0; m_cause = 0;
    endtask

    // One request cycle: drive at negedge, check stall, advance the model, check registered outputs.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic sg, input logic [1:0] ls, input logic [1:0] ss, input logic rdy);
        logic [1:0] c;
        logic in_d, do_pop, exp_stall;
        logic [31:0] v;
        int n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        load_signed = sg; load_size = ls; store_size = ss; uart_tx_ready = rdy;
        in_d = (a >= BASE) && (a - BASE < BYTES);
        c = 2'b00;
        if (rd && wr) c = 2'b11;
        else if (rd && !in_d && a != STA) c = 2'b11;
        else if (wr && !in_d && a != TXA) c = 2'b11;
        else if (rd && in_d && a % nbytes(ls) != 0) c = 2'b01;
        else if (wr && in_d && a % nbytes(ss) != 0) c = 2'b10;
        exp_stall = wr && c == 2'b00 && a == TXA && q.size() == DEPTH;
        #1;
        last_stall = stall;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        if (rd && c == 2'b00) begin
            if (a == STA) m_rdata = {30'b0, q.size() == 0, q.size() == DEPTH};
            else begin
                n = nbytes(ls);
                v = 0;
                for (int i = 0; i < n; i++) v |= 32'(mdl[a + i]) << (8 * i);
                if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
                m_rdata = v;
            end
        end
        m_rvalid = rd && c == 2'b00;
        m_fault  = c != 2'b00;
        m_cause  = c;
        do_pop = q.size() > 0 && rdy;
        if (wr && c == 2'b00 && in_d)
            for (int i = 0; i < nbytes(ss); i++) mdl[a + i] = wd[8*i +: 8];
        if (do_pop) void'(q.pop_front());
        if (wr && c == 2'b00 && a == TXA && !exp_stall) q.push_back(wd[7:0]);
        @(posedge clk);
        #1;
        chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        if (m_fault) chk("cause", {30'b0, fault_cause}, {30'b0, m_cause});
        chk("rdata", rdata, m_rdata);
        chk("tx_valid", {31'b0, uart_tx_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) chk("tx_data", {24'b0, uart_tx_data}, {24'b0, q[0]});
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, 0, 0, 2'b00, 2'b00, rdy);
    endtask

    typedef struct {
        logic rd, wr; logic [31:0] a, wd; logic sg; logic [1:0] ls, ss;
        logic e_rv, e_f; logic [1:0] e_c; logic [31:0] e_rd;
    } vec_t;
    vec_t tbl [12];

    logic [31:0] ra;
    int k;

    initial begin
        tbl[0]  = '{0, 1, 32'h1000_0000, 32'h1122_3344, 0, 2'b00, 2'b10, 0, 0, 2'b00, 32'h0};
        tbl[1]  = '{0, 1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 2'b00, 2'b10, 0, 0, 2'b00, 32'h0};
        tbl[2]  = '{1, 0, 32'h1000_0013, 32'h0,         1, 2'b00, 2'b00, 1, 0, 2'b00, 32'hFFFF_FFDE};
        tbl[3]  = '{1, 0, 32'h1000_0012, 32'h0,         0, 2'b01, 2'b00, 1, 0, 2'b00, 32'h0000_DEAD};
        tbl[4]  = '{1, 0, 32'h1000_0002, 32'h0,         0, 2'b10, 2'b00, 0, 1, 2'b01, 32'h0000_DEAD};
        tbl[5]  = '{0, 1, 32'h1000_0001, 32'h1234,      0, 2'b00, 2'b01, 0, 1, 2'b10, 32'h0000_DEAD};
        tbl[6]  = '{1, 0, 32'h1000_0000, 32'h0,         0, 2'b10, 2'b00, 1, 0, 2'b00, 32'h1122_3344};
        tbl[7]  = '{1, 0, 32'h0000_0100, 32'h0,         0, 2'b10, 2'b00, 0, 1, 2'b11, 32'h1122_3344};
        tbl[8]  = '{0, 1, 32'h1002_0000, 32'h77,        0, 2'b00, 2'b00, 0, 1, 2'b11, 32'h1122_3344};
        tbl[9]  = '{0, 1, 32'h1001_FFFF, 32'h5A,        0, 2'b00, 2'b00, 0, 0, 2'b00, 32'h1122_3344};
        tbl[10] = '{1, 1, 32'h1000_0000, 32'h0,         0, 2'b10, 2'b10, 0, 1, 2'b11, 32'h1122_3344};
        tbl[11] = '{1, 0, 32'h1000_0000, 32'h0,         0, 2'b10, 2'b00, 1, 0, 2'b00, 32'h1122_3344};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_cause", {30'b0, fault_cause}, 0);
        chk("rst_txv", {31'b0, uart_tx_valid}, 0);
        chk("rst_txd", {24'b0, uart_tx_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sg, tbl[i].ls, tbl[i].ss, 0);
            chk($sformatf("tbl%0d_rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].e_rv});
            chk($sformatf("tbl%0d_fault", i), {31'b0, fault}, {31'b0, tbl[i].e_f});
            if (tbl[i].e_f) chk($sformatf("tbl%0d_cause", i), {30'b0, fault_cause}, {30'b0, tbl[i].e_c});
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rd);
        end
        step(1, 0, 32'h1001_FFFF, 0, 0, 2'b00, 2'b00, 0);
        chk("last_byte", rdata, 32'h5A);

        // Back-pressure: fill, stall on the ninth, one pop frees a slot, retry lands.
        for (int i = 0; i < 8; i++) step(0, 1, TXA, 32'h41 + i, 0, 2'b00, 2'b00, 0);
        step(0, 1, TXA, 32'h49, 0, 2'b00, 2'b00, 0);
        chk("stall_9th", {31'b0, last_stall}, 1);
        step(1, 0, STA, 0, 0, 2'b10, 2'b00, 0);
        chk("stat_full", rdata, 32'h1);
        step(0, 1, TXA, 32'h49, 0, 2'b00, 2'b00, 1);
        chk("stall_on_pop", {31'b0, last_stall}, 1);
        chk("head_after_pop", {24'b0, uart_tx_data}, 32'h42);
        step(0, 1, TXA, 32'h49, 0, 2'b00, 2'b00, 0);
        chk("retry_ok", {31'b0, last_stall}, 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain", {24'b0, uart_tx_data}, 32'h42 + i);
            idle(1);
        end
        chk("drained", {31'b0, uart_tx_valid}, 0);

        // Simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) step(0, 1, TXA, 32'h61 + i, 0, 2'b00, 2'b00, 0);
        step(0, 1, TXA, 32'h64, 0, 2'b00, 2'b00, 1);
        chk("pp_head", {24'b0, uart_tx_data}, 32'h62);
        step(1, 0, STA, 0, 0, 2'b10, 2'b00, 0);
        chk("pp_stat", rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("pp_order", {24'b0, uart_tx_data}, 32'h62 + i);
            idle(1);
        end

        // Reset mid-drain with a fault pulse pending.
        for (int i = 0; i < 5; i++) step(0, 1, TXA, 32'h70 + i, 0, 2'b00, 2'b00, 0);
        step(1, 0, 32'h0000_0100, 0, 0, 2'b10, 2'b00, 0);
        chk("pre_rst_fault", {31'b0, fault}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txv", {31'b0, uart_tx_valid}, 0);
        chk("rst_mid_fault", {31'b0, fault}, 0);
        chk("rst_mid_rvalid", {31'b0, rvalid}, 0);
        chk("rst_mid_txd", {24'b0, uart_tx_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, STA, 0, 0, 2'b10, 2'b00, 0);
        chk("stat_empty", rdata, 32'h2);

        // Random traffic over a pre-initialised window.
        for (int i = 0; i < 64; i += 4) step(0, 1, BASE + i, $urandom, 0, 2'b00, 2'b10, $urandom_range(0, 1));
        for (int i = 0; i < 8; i += 4) step(0, 1, BASE + BYTES - 8 + i, $urandom, 0, 2'b00, 2'b10, 0);
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0, 1: ra = BASE + $urandom_range(0, 63);
                2:    ra = TXA;
                3:    ra = STA;
                4:    ra = BASE + BYTES - 8 + $urandom_range(0, 7);
                default: ra = ($urandom_range(0, 1) != 0) ? 32'h0000_0100 + $urandom_range(0, 15)
                                                           : BASE + BYTES + $urandom_range(0, 3);
            endcase
            step(k < 4 || k == 8, (k >= 4 && k < 8) || k == 8, ra, $urandom, 1'($urandom),
                 2'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_unit.md
# dmem_mmio_unit

Parametrised data-memory and MMIO unit for the MEM stage of the pipelined core. It replaces simulation-only fatal checks with architectural fault reporting. It adds a buffered UART TX queue with ready/valid drain and back-pressure (stall) to the pipeline, plus a readable UART status register. Loads keep the 1-cycle synchronous-read contract: data is valid in the cycle after the request.

## Interface
Parameters:
- DMEM_BASE, 32'h1000_0000, byte base address of DMEM
- DMEM_BYTES, 131072, DMEM size in bytes; multiple of 4
- UART_TX_ADDR, 32'h2000_0000, TX data register (write-only)
- UART_STAT_ADDR, 32'h2000_0004, status register (read-only)
- TXQ_DEPTH, 8, UART TX queue entries; power of 2, ≥2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load request this cycle
- mem_write  in  1  store request this cycle
- addr  in  32  effective address
- wdata  in  32  store data
- load_signed  in  1  1 = sign-extend, 0 = zero-extend
- load_size  in  2  00 byte, 01 half, 1x word
- store_size  in  2  00 byte, 01 half, 1x word
- rdata  out  32  registered load data
- rvalid  out  1  registered; rdata valid for a legal load issued the previous cycle
- fault  out  1  registered; request issued the previous cycle was illegal
- fault_cause  out  2  01 misaligned load, 10 misaligned store, 11 access fault
- stall  out  1  combinational; store to TX blocked, hold request
- uart_tx_data  out  8  queue head byte
- uart_tx_valid  out  1  queue non-empty
- uart_tx_ready  in  1  sink accepts head this cycle

## Operation
- Decode:
  - in_dmem = addr ≥ DMEM_BASE and addr−DMEM_BASE < DMEM_BYTES.
  - is_tx = addr==UART_TX_ADDR.
  - is_stat = addr==UART_STAT_ADDR.
- Legality is checked in priority order. The first match sets the cause; a faulting request has no side effect and leaves rdata unchanged.
  1. mem_read and mem_write both high → 11.
  2. Load not in_dmem and not is_stat → 11.
  3. Store not in_dmem and not is_tx → 11.
  4. In-DMEM load, half with addr[0]≠0 or word with addr[1:0]≠0 → 01.
  5. In-DMEM store, same alignment rule → 10.
- MMIO accesses ignore size and alignment.
- DMEM load: little-endian assembly of 1/2/4 bytes at offset, extended per load_signed, registered into rdata; rvalid=1 next cycle.
- Status load: rdata = {30'b0, txq_empty, txq_full}, sampled at the request edge; rvalid=1.
- DMEM store: byte lanes written little-endian at the edge. Word store writes 4 bytes, half writes 2, byte writes 1. Contents are not reset.
- TX store:
  - If queue not full: push wdata[7:0] at the edge.
  - If full: stall=1, no push. The requester holds all inputs until stall=0.
- TX queue: circular buffer with wrap-around read/write pointers and a count of width log2(TXQ_DEPTH)+1. Pop when uart_tx_valid && uart_tx_ready.
- Simultaneous push and pop:
  - Not full: count unchanged, both take effect.
  - Full: stall is computed from the pre-edge full flag, so the pop proceeds and the push is blocked that cycle (the retry succeeds next cycle).

## Timing
- Reset (async assert, sync-safe deassert): rdata=0, rvalid=0, fault=0, fault_cause=00, queue empty, uart_tx_valid=0, uart_tx_data=0 (head of cleared storage). Queued bytes are discarded on reset mid-operation.
- Load latency: 1 cycle. rvalid and fault are 1-cycle pulses per request and are never both high.
- Store-then-load to the same address in consecutive cycles returns the newly stored data.
- Depends on stall: the request inputs, full flag and current cycle only. It has no dependence on uart_tx_ready (no combinational path ready→stall).
- First byte is visible on uart_tx_data/valid the cycle after the push edge.
- Throughput: one push and one pop per cycle.

## Test plan
- Load after store:
  - SW 0xDEADBEEF @0x1000_0010, then LB @0x1000_0013 → next cycle rdata=0xFFFFFFDE, rvalid=1.
  - LHU @0x1000_0012 → rdata=0x0000DEAD.
- Misalignment:
  - LW @0x1000_0002 → fault=1, cause=01, rvalid=0, rdata unchanged.
  - SH @0x1000_0001 with wdata 0x1234 → cause=10, memory unchanged (verify with LW).
- Access fault:
  - LW @0x0000_0100 → cause=11.
  - SB @0x1002_0000 (first byte past end) → cause=11.
  - mem_read=mem_write=1 → cause=11, no write.
- TX queue back-pressure:
  - uart_tx_ready=0, push 9 bytes 0x41..0x49 (depth 8). Bytes 1–8 accepted; stall=1 on the 9th.
  - Status LW → rdata=0x1.
  - Raise ready for 1 cycle → 0x41 popped; 9th push accepted next cycle.
  - Drain order is 0x42..0x49, with pointer wrap-around.
- Simultaneous push/pop at count=3 with ready=1 → count stays 3, order preserved.
- Reset mid-drain: assert rst_n=0 with 5 queued bytes → uart_tx_valid=0 immediately; rvalid=fault=0. Status load after release → 0x2 (empty).
